// File: rtl/vdp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vdp_pkg : shared VDP constants and VRAM arbiter state encoding       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package vdp_pkg;

    localparam int VRAM_AW          = 14;
    localparam int VRAM_DW          = 8;
    localparam int STARVE_LIMIT_DEF = 512;

    typedef logic [1:0] arb_state_t;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WR_PEND = 2'd1;
    localparam logic [1:0] ST_RD_PEND = 2'd2;
    localparam logic [1:0] ST_RD_CAP  = 2'd3;

    function automatic logic is_pending(input arb_state_t s);
        return (s == ST_WR_PEND) || (s == ST_RD_PEND);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vdp_vram_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vdp_vram_arbiter_if : renderer, CPU data port and RAM port bundle    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface vdp_vram_arbiter_if #(
    parameter int AW = vdp_pkg::VRAM_AW,
    parameter int DW = vdp_pkg::VRAM_DW
);
    logic          render_req;
    logic [AW-1:0] render_addr;
    logic [DW-1:0] render_data;
    logic          render_valid;

    logic          cpu_addr_we;
    logic [AW-1:0] cpu_addr;
    logic          cpu_addr_rd;
    logic          cpu_wr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_rd;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_busy;
    logic          cpu_starve;
    logic          cpu_err;
    logic          err_clr;

    logic [AW-1:0] vram_addr;
    logic          vram_we;
    logic [DW-1:0] vram_di;
    logic [DW-1:0] vram_do;

    // Master is the surrounding system (renderer, CPU decoder, RAM).
    modport master (
        output render_req, render_addr,
        output cpu_addr_we, cpu_addr, cpu_addr_rd, cpu_wr, cpu_wdata, cpu_rd, err_clr,
        output vram_do,
        input  render_data, render_valid,
        input  cpu_rdata, cpu_busy, cpu_starve, cpu_err,
        input  vram_addr, vram_we, vram_di
    );

    modport slave (
        input  render_req, render_addr,
        input  cpu_addr_we, cpu_addr, cpu_addr_rd, cpu_wr, cpu_wdata, cpu_rd, err_clr,
        input  vram_do,
        output render_data, render_valid,
        output cpu_rdata, cpu_busy, cpu_starve, cpu_err,
        output vram_addr, vram_we, vram_di
    );
endinterface
`default_nettype wire

// File: rtl/vdp_vram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vdp_vram_arbiter : renderer-priority VRAM port sharing with CPU port |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module vdp_vram_arbiter
    import vdp_pkg::*;
#(
    parameter int AW           = VRAM_AW,
    parameter int DW           = VRAM_DW,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    vdp_vram_arbiter_if.slave bus
);

    localparam int            CW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] C_LIM = CW'(STARVE_LIMIT);

    arb_state_t    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, starve_q, err_q, rvalid_q;
    logic          err_d;

    logic          w_idle, w_free, w_any, w_multi, w_drop;

    assign w_idle  = (state_q == ST_IDLE);
    assign w_free  = ~bus.render_req;
    assign w_any   = bus.cpu_addr_we | bus.cpu_wr | bus.cpu_rd;
    assign w_multi = (bus.cpu_addr_we & bus.cpu_wr) | (bus.cpu_addr_we & bus.cpu_rd)
                   | (bus.cpu_wr & bus.cpu_rd);
    // Only one strobe can be accepted, and only while idle.
    assign w_drop  = w_idle ? w_multi : w_any;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.cpu_addr_we) begin
                    addr_d = bus.cpu_addr;
                    if (bus.cpu_addr_rd) begin
                        state_d = ST_RD_PEND;
                    end
                end else if (bus.cpu_wr) begin
                    waddr_d = addr_q;
                    wdata_d = bus.cpu_wdata;
                    rdata_d = bus.cpu_wdata;
                    state_d = ST_WR_PEND;
                end else if (bus.cpu_rd) begin
                    state_d = ST_RD_PEND;
                end
            end
            ST_WR_PEND: begin
                if (w_free) begin
                    addr_d  = addr_q + AW'(1);
                    state_d = ST_IDLE;
                end
            end
            ST_RD_PEND: begin
                if (w_free) begin
                    state_d = ST_RD_CAP;
                end
            end
            default: begin
                rdata_d = bus.vram_do;
                addr_d  = addr_q + AW'(1);
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        cnt_d = '0;
        if (is_pending(state_q) && (state_d == state_q)) begin
            cnt_d = (cnt_q == C_LIM) ? cnt_q : cnt_q + CW'(1);
        end
    end

    // Set before clear: a simultaneous drop and clear leaves the flag low.
    assign err_d = (err_q | w_drop) & ~bus.err_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            starve_q <= 1'b0;
            err_q    <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            cnt_q    <= cnt_d;
            busy_q   <= (state_d != ST_IDLE);
            starve_q <= (cnt_d == C_LIM);
            err_q    <= err_d;
            rvalid_q <= bus.render_req;
        end
    end

    // The renderer owns the port whenever it requests, whatever the CPU state.
    always_comb begin
        bus.vram_addr = '0;
        bus.vram_we   = 1'b0;
        bus.vram_di   = '0;
        if (bus.render_req) begin
            bus.vram_addr = bus.render_addr;
        end else if (state_q == ST_WR_PEND) begin
            bus.vram_addr = waddr_q;
            bus.vram_we   = 1'b1;
            bus.vram_di   = wdata_q;
        end else if (state_q == ST_RD_PEND) begin
            bus.vram_addr = addr_q;
        end
    end

    assign bus.render_data  = bus.vram_do;
    assign bus.render_valid = rvalid_q;
    assign bus.cpu_rdata    = rdata_q;
    assign bus.cpu_busy     = busy_q;
    assign bus.cpu_starve   = starve_q;
    assign bus.cpu_err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_vdp_vram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vdp_vram_arbiter : directed and random bench with reference model |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_vdp_vram_arbiter;
    import vdp_pkg::*;

    localparam int AW  = 14;
    localparam int DW  = 8;
    localparam int LIM = 512;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vdp_vram_arbiter_if #(.AW(AW), .DW(DW)) bus();

    vdp_vram_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int we_cnt   = 0;

    logic [7:0] ram  [0:(1<<AW)-1];
    logic [7:0] mmem [0:(1<<AW)-1];

    // Synchronous-read single-port RAM seen by the DUT
    always @(posedge clk) begin
        if (bus.vram_we) ram[bus.vram_addr] <= bus.vram_di;
        bus.vram_do <= ram[bus.vram_addr];
    end

    always @(posedge clk) if (bus.vram_we) we_cnt++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding CPU operation (0 none, 1 write waiting,
    // 2 read waiting, 3 read data arriving) plus the port's architectural state.
    int         m_op;
    int         m_wait;
    logic [13:0] m_addr, m_waddr;
    logic [7:0]  m_wdata, m_rdata, m_rexp;
    logic        m_err, m_rv;

    always @(posedge clk or negedge rst_n) begin
        int   n;
        logic was_busy, set, free;
        if (!rst_n) begin
            m_op = 0; m_wait = 0; m_addr = '0; m_waddr = '0; m_wdata = '0;
            m_rdata = '0; m_rexp = '0; m_err = 1'b0; m_rv = 1'b0;
        end else begin
            free     = !bus.render_req;
            was_busy = (m_op != 0);
            n        = int'(bus.cpu_addr_we) + int'(bus.cpu_wr) + int'(bus.cpu_rd);
            m_rv     = bus.render_req;
            m_rexp   = mmem[bus.render_addr];
            case (m_op)
                3: begin
                    m_rdata = mmem[m_addr];
                    m_addr  = m_addr + 14'd1;
                    m_op    = 0;
                end
                1: begin
                    if (free) begin
                        mmem[m_waddr] = m_wdata;
                        m_addr = m_addr + 14'd1;
                        m_op = 0; m_wait = 0;
                    end else if (m_wait < LIM) m_wait++;
                end
                2: begin
                    if (free) begin m_op = 3; m_wait = 0; end
                    else if (m_wait < LIM) m_wait++;
                end
                default: begin
                    if (bus.cpu_addr_we) begin
                        m_addr = bus.cpu_addr;
                        if (bus.cpu_addr_rd) m_op = 2;
                    end else if (bus.cpu_wr) begin
                        m_waddr = m_addr; m_wdata = bus.cpu_wdata;
                        m_rdata = bus.cpu_wdata; m_op = 1;
                    end else if (bus.cpu_rd) m_op = 2;
                end
            endcase
            set   = was_busy ? (n > 0) : (n > 1);
            m_err = (m_err | set) & !bus.err_clr;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("render_valid", bus.render_valid, m_rv);
            if (m_rv) chk("render_data", bus.render_data, m_rexp);
            chk("vram_we", bus.vram_we, (!bus.render_req && m_op == 1));
            if (bus.render_req) chk("vram_addr_render", bus.vram_addr, bus.render_addr);
            else if (m_op == 1) begin
                chk("vram_addr_wr", bus.vram_addr, m_waddr);
                chk("vram_di", bus.vram_di, m_wdata);
            end else if (m_op == 2) chk("vram_addr_rd", bus.vram_addr, m_addr);
            chk("cpu_rdata", bus.cpu_rdata, m_rdata);
            chk("cpu_busy", bus.cpu_busy, m_op != 0);
            chk("cpu_starve", bus.cpu_starve, m_wait == LIM);
            chk("cpu_err", bus.cpu_err, m_err);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        bus.cpu_addr_we = 1'b0; bus.cpu_addr_rd = 1'b0;
        bus.cpu_wr = 1'b0; bus.cpu_rd = 1'b0; bus.err_clr = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 20 && bus.cpu_busy; k++) tick();
        chk("idle_timeout", bus.cpu_busy, 1'b0);
    endtask

    task automatic put(input int a, input logic [7:0] v);
        ram[a] = v; mmem[a] = v;
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_busy"}, bus.cpu_busy, 0);
        chk({nm, "_starve"}, bus.cpu_starve, 0);
        chk({nm, "_err"}, bus.cpu_err, 0);
        chk({nm, "_rvalid"}, bus.render_valid, 0);
        chk({nm, "_we"}, bus.vram_we, 0);
        chk({nm, "_addr"}, bus.vram_addr, 0);
        chk({nm, "_di"}, bus.vram_di, 0);
        chk({nm, "_rdata"}, bus.cpu_rdata, 0);
    endtask

    initial begin
        int w0, first;
        bus.render_req = 1'b0; bus.render_addr = '0;
        bus.cpu_addr_we = 1'b0; bus.cpu_addr = '0; bus.cpu_addr_rd = 1'b0;
        bus.cpu_wr = 1'b0; bus.cpu_wdata = '0; bus.cpu_rd = 1'b0; bus.err_clr = 1'b0;
        for (int i = 0; i < (1 << AW); i++) put(i, 8'($urandom));

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        @(posedge clk); #2; rst_n = 1'b1;

        // Renderer stream, no CPU traffic
        for (int j = 0; j < 256; j++) put(16'h3800 + j, 8'(j) ^ 8'h5A);
        w0 = we_cnt;
        for (int i = 0; i < 256; i++) begin
            bus.render_req = 1'b1; bus.render_addr = 14'(16'h3800 + i);
            tick();
            chk("stream_valid", bus.render_valid, 1);
            chk("stream_data", bus.render_data, 8'(i) ^ 8'h5A);
        end
        bus.render_req = 1'b0;
        tick();
        chk("stream_valid_end", bus.render_valid, 0);
        chk("stream_no_we", we_cnt - w0, 0);

        // Address wrap on write
        put(1, 8'h77);
        bus.cpu_addr_we = 1'b1; bus.cpu_addr = 14'h3FFF; tick();
        chk("addr_only_not_busy", bus.cpu_busy, 0);
        bus.cpu_wr = 1'b1; bus.cpu_wdata = 8'hAA; tick();
        chk("wr_busy", bus.cpu_busy, 1);
        wait_idle();
        bus.cpu_wr = 1'b1; bus.cpu_wdata = 8'h55; tick();
        wait_idle();
        chk("wrap_ram_3fff", ram[14'h3FFF], 8'hAA);
        chk("wrap_ram_0000", ram[0], 8'h55);
        chk("wrap_rdata", bus.cpu_rdata, 8'h55);
        bus.cpu_rd = 1'b1; tick(); wait_idle();
        chk("wrap_addr_1", bus.cpu_rdata, 8'h77);

        // Prefetch then read
        put(16'h0100, 8'h12); put(16'h0101, 8'h34); put(16'h0102, 8'h56);
        bus.cpu_addr_we = 1'b1; bus.cpu_addr = 14'h0100; bus.cpu_addr_rd = 1'b1; tick();
        wait_idle();
        chk("prefetch_12", bus.cpu_rdata, 8'h12);
        bus.cpu_rd = 1'b1; tick(); wait_idle();
        chk("read_34", bus.cpu_rdata, 8'h34);
        bus.cpu_rd = 1'b1; tick(); wait_idle();
        chk("read_56", bus.cpu_rdata, 8'h56);

        // Starvation under a continuous renderer stream; write lands at 0x0103
        bus.render_req = 1'b1; bus.render_addr = 14'h2000;
        bus.cpu_wr = 1'b1; bus.cpu_wdata = 8'hC3; tick();
        w0 = we_cnt; first = 0;
        for (int i = 1; i <= 600; i++) begin
            tick();
            if (first == 0 && bus.cpu_starve) first = i;
        end
        chk("starve_rise_cycle", first, 512);
        chk("starve_no_cpu_cycle", we_cnt - w0, 0);
        chk("starve_high", bus.cpu_starve, 1);
        bus.render_req = 1'b0; tick();
        chk("starve_write_lands", we_cnt - w0, 1);
        chk("starve_clear", bus.cpu_starve, 0);
        chk("starve_ram", ram[14'h0103], 8'hC3);

        // Dropped strobes and sticky error
        bus.cpu_wr = 1'b1; bus.cpu_wdata = 8'h9E; bus.cpu_rd = 1'b1; tick();
        chk("drop_err", bus.cpu_err, 1);
        bus.cpu_rd = 1'b1; tick();
        chk("drop_ram", ram[14'h0104], 8'h9E);
        chk("drop_rdata", bus.cpu_rdata, 8'h9E);
        tick(); tick();
        chk("err_sticky", bus.cpu_err, 1);
        bus.err_clr = 1'b1; tick();
        chk("err_cleared", bus.cpu_err, 0);
        bus.cpu_wr = 1'b1; bus.cpu_rd = 1'b1; bus.err_clr = 1'b1; tick();
        chk("err_set_clr_same", bus.cpu_err, 0);
        wait_idle();

        // Reset during a pending write
        bus.render_req = 1'b1; bus.cpu_wr = 1'b1; bus.cpu_wdata = 8'hE7; tick(); tick();
        chk("rst_pend_busy", bus.cpu_busy, 1);
        w0 = we_cnt;
        rst_n = 1'b0; bus.render_req = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        tick(); tick();
        @(posedge clk); #2; rst_n = 1'b1;
        tick();
        chk("midrst_idle", bus.cpu_busy, 0);
        chk("midrst_no_we", we_cnt - w0, 0);

        // Random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            bus.render_req  = ((c % 700) < 30) || ($urandom_range(99) < 55);
            bus.render_addr = 14'($urandom);
            bus.cpu_addr_we = $urandom_range(99) < 8;
            bus.cpu_addr    = 14'($urandom);
            bus.cpu_addr_rd = 1'($urandom);
            bus.cpu_wr      = $urandom_range(99) < 12;
            bus.cpu_wdata   = 8'($urandom);
            bus.cpu_rd      = $urandom_range(99) < 12;
            bus.err_clr     = $urandom_range(99) < 4;
            tick();
        end
        bus.render_req = 1'b0;
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
